pipeline_hazard_ctrl: RTL

- Parametrised hazard and flush controller for the RV32IM pipeline. It replaces the fixed two-register load-use/branch flush logic.
- Drives per-pipeline-register HOLD/RESET vectors and PC_HOLD for the following events: load-use stalls (multi-cycle capable), taken branch/jump flushes of configurable depth, multiply/divide unit busy stalls, and data-memory wait freezes.
- Sits beside the hazard detection unit and between the MDU and data-memory interface.
- Also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller: turns load-use, branch, MDU-busy and DMEM-busy events into
// per-pipeline-register hold/clear vectors, a PC hold and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned NUM_PR          = 4,
    parameter int unsigned FLUSH_DEPTH     = 2,
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LU_HAZ_SIGNAL,
    input  logic              BRANCH_SEL,
    input  logic              MDU_BUSY,
    input  logic              DMEM_BUSY,
    output logic              PC_HOLD,
    output logic [NUM_PR-1:0] PR_HOLD,
    output logic [NUM_PR-1:0] PR_RESET,
    output logic [CNT_W-1:0]  STALL_COUNT,
    output logic [1:0]        FSM_STATE
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StLuStall = 2'd1;
    localparam logic [1:0] StMduWait = 2'd2;
    localparam logic [1:0] StMemWait = 2'd3;

    localparam logic [3:0] LuReload = 4'(LU_STALL_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       lu_cnt_q, lu_cnt_d;
    logic             br_pend_q, br_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic flush;
    logic lu_active;

    assign flush = BRANCH_SEL | br_pend_q;
    // A nonzero counter means bubbles are still owed, including while suspended by a wait.
    assign lu_active = (lu_cnt_q != 4'd0);

    always_comb begin
        state_d   = StIdle;
        lu_cnt_d  = lu_cnt_q;
        br_pend_d = br_pend_q;
        PC_HOLD   = 1'b0;
        PR_HOLD   = '0;
        PR_RESET  = '0;

        if (DMEM_BUSY) begin
            PC_HOLD   = 1'b1;
            PR_HOLD   = '1;
            state_d   = StMemWait;
            br_pend_d = br_pend_q | BRANCH_SEL;
        end else if (MDU_BUSY) begin
            PC_HOLD     = 1'b1;
            PR_HOLD[0]  = 1'b1;
            PR_HOLD[1]  = 1'b1;
            PR_RESET[2] = 1'b1;
            state_d     = StMduWait;
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_PR; i++) begin
                PR_RESET[i] = (i < FLUSH_DEPTH);
            end
            br_pend_d = 1'b0;
            lu_cnt_d  = 4'd0;
            state_d   = StIdle;
        end else if (lu_active) begin
            PC_HOLD     = 1'b1;
            PR_HOLD[0]  = 1'b1;
            PR_RESET[1] = 1'b1;
            if (lu_cnt_q == 4'd1) begin
                lu_cnt_d = 4'd0;
                state_d  = StIdle;
            end else begin
                lu_cnt_d = lu_cnt_q - 4'd1;
                state_d  = StLuStall;
            end
        end else if (LU_HAZ_SIGNAL) begin
            PC_HOLD     = 1'b1;
            PR_HOLD[0]  = 1'b1;
            PR_RESET[1] = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                lu_cnt_d = LuReload;
                state_d  = StLuStall;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (PC_HOLD && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            lu_cnt_q  <= 4'd0;
            br_pend_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            br_pend_q <= br_pend_d;
            cnt_q     <= cnt_d;
        end
    end

    assign STALL_COUNT = cnt_q;
    assign FSM_STATE   = state_q;

endmodule
